gen_frame_sched: RTL and testbench

GEN_FRAME_SCHED -- requirements
Module: gen_frame_sched

---
 rtl/gen_frame_sched_pkg.sv | 16 +
 rtl/gen_frame_sched_rr_arb2.sv | 21 ++
 rtl/gen_frame_sched.sv | 119 +++++++++++
 tb/tb_gen_frame_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_frame_sched_pkg.sv
// Shared types and defaults for the frame scheduler.
package gen_frame_sched_pkg;

  // Default width of frame-length fields and beat counters.
  localparam int unsigned LenWDefault = 16;

  // Scheduler FSM encoding.
  typedef enum logic [2:0] {
    StIdle,
    StRestart,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/gen_frame_sched_rr_arb2.sv
// Two-way round-robin arbiter; 'last' is the index of the previously granted requester.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant
);

  // On a tie, favour the requester that did not win last time.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant = last ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/gen_frame_sched.sv
// Schedules fixed-length frames from a power-of-3 generator between two requesters.
module gen_frame_sched
  import gen_frame_sched_pkg::*;
#(
  parameter int unsigned LEN_W = LenWDefault
) (
  input  logic             m00_axis_aclk,
  input  logic             m00_axis_areset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy,
  input  logic             m00_axis_tready,
  input  logic             gen_tvalid,
  output logic             gen_enable,
  output logic             gen_aresetn,
  output logic             frame_tlast
);

  localparam logic [LEN_W-1:0] One = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] emitted_q, emitted_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic             gen_aresetn_q;
  logic [1:0]       arb_grant;
  logic             issue;
  logic             beat;
  logic             active;

  rr_arb2 u_arb (
    .req   (req),
    .last  (last_q),
    .en    (state_q == StIdle),
    .grant (arb_grant)
  );

  assign active = (state_q == StRun) || (state_q == StDrain);
  assign issue  = gen_enable && m00_axis_tready;
  assign beat   = gen_tvalid && active;

  // Next-state logic: latch a frame in IDLE, count issued and emitted beats, retire in DONE.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    emitted_d = emitted_q;
    grant_d   = grant_q;
    last_d    = last_q;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          grant_d   = arb_grant;
          len_d     = arb_grant[1] ? req_len1 : req_len0;
          issued_d  = '0;
          emitted_d = '0;
          state_d   = StRestart;
        end
      end
      StRestart: begin
        state_d = (len_q == '0) ? StDone : StRun;
      end
      StRun: begin
        if (issue) issued_d = issued_q + One;
        if (beat) emitted_d = emitted_q + One;
        // issued_q < len_q whenever issue is high, so the increment cannot wrap.
        if (issue && (issued_q + One == len_q)) state_d = StDrain;
      end
      StDrain: begin
        if (beat) emitted_d = emitted_q + One;
        // Leave as soon as the final beat is seen so DRAIN normally lasts one cycle.
        if ((emitted_q == len_q) || (beat && (emitted_q + One == len_q))) state_d = StDone;
      end
      StDone: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q       <= StIdle;
      len_q         <= '0;
      issued_q      <= '0;
      emitted_q     <= '0;
      grant_q       <= 2'b00;
      last_q        <= 1'b1;
      gen_aresetn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      emitted_q     <= emitted_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      gen_aresetn_q <= (state_d != StRestart);
    end
  end

  // Outputs decoded from registered state; frame_tlast also follows gen_tvalid.
  always_comb begin
    grant       = grant_q;
    done        = (state_q == StDone) ? grant_q : 2'b00;
    busy        = (state_q != StIdle);
    gen_enable  = (state_q == StRun) && (issued_q < len_q);
    gen_aresetn = gen_aresetn_q;
    frame_tlast = beat && (len_q != '0) && (emitted_q == len_q - One);
  end

endmodule

// File: tb/tb_gen_frame_sched.sv
// Randomised self-checking bench for gen_frame_sched with a power-of-3 generator model.
module tb_gen_frame_sched;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         areset;
  logic [1:0]   req;
  logic [W-1:0] req_len0, req_len1;
  logic [1:0]   grant, done;
  logic         busy, tready, gen_tvalid, gen_enable, gen_aresetn, frame_tlast;
  logic [31:0]  gen_data;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_last = 1;

  logic [1:0]  obs_grant, obs_done_val, obs_gap_grant, obs_gap_done;
  int          obs_rst_cycles, obs_en_cycles, obs_issues, obs_beats;
  int          obs_tlast_cnt, obs_tlast_idx, obs_done_cnt, obs_cycles;
  bit          obs_timeout;
  logic [31:0] obs_data[$];

  always #5 clk = ~clk;

  gen_frame_sched #(.LEN_W(W)) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (areset),
    .req             (req),
    .req_len0        (req_len0),
    .req_len1        (req_len1),
    .grant           (grant),
    .done            (done),
    .busy            (busy),
    .m00_axis_tready (tready),
    .gen_tvalid      (gen_tvalid),
    .gen_enable      (gen_enable),
    .gen_aresetn     (gen_aresetn),
    .frame_tlast     (frame_tlast)
  );

  // Generator: each accepted enable yields one valid beat next cycle, value 3^n.
  always_ff @(posedge clk) begin
    if (!gen_aresetn) begin
      gen_data   <= 32'd1;
      gen_tvalid <= 1'b0;
    end else begin
      gen_tvalid <= gen_enable && tready;
      if (gen_enable && tready) gen_data <= gen_data * 32'd3;
    end
  end

  function automatic logic [31:0] pow3(input int n);
    logic [31:0] v = 32'd1;
    for (int i = 0; i < n; i++) v = v * 32'd3;
    return v;
  endfunction

  // Round-robin reference: on a tie the requester not granted last wins.
  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return (exp_last == 0) ? 1 : 0;
    return r[1] ? 1 : 0;
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    req = 2'b00;
    tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    exp_last = 1;
    @(negedge clk);
  endtask

  // Drive one request and record what happens until the frame's done pulse and the cycle after.
  // tmode: 0 ready high, 1 toggling, 2 random, 3 low for 40 cycles then high.
  task automatic run_frame(input logic [1:0] r, input logic [W-1:0] l0, input logic [W-1:0] l1,
                           input int tmode, input bit hold, input bit chg);
    bit got = 0;
    obs_grant = 2'b00; obs_done_val = 2'b00; obs_gap_grant = 2'b00; obs_gap_done = 2'b00;
    obs_rst_cycles = 0; obs_en_cycles = 0; obs_issues = 0; obs_beats = 0;
    obs_tlast_cnt = 0; obs_tlast_idx = 0; obs_done_cnt = 0; obs_cycles = 0;
    obs_timeout = 0;
    obs_data.delete();
    req = r; req_len0 = l0; req_len1 = l1;
    tready = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (grant != 2'b00) got = 1;
    end
    if (!got) begin
      obs_timeout = 1;
      req = 2'b00;
      return;
    end
    obs_grant = grant;
    if (!gen_aresetn) obs_rst_cycles++;
    if (!hold) req = 2'b00;
    if (chg) begin
      req_len0 = l0 + W'(4);
      req_len1 = l1 + W'(4);
    end
    got = 0;
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      @(posedge clk);
      #1;
      case (tmode)
        1: tready = ~tready;
        2: tready = 1'($urandom);
        3: tready = (cyc >= 40);
        default: tready = 1'b1;
      endcase
      @(negedge clk);
      obs_cycles++;
      if (!gen_aresetn) obs_rst_cycles++;
      if (gen_enable) obs_en_cycles++;
      if (gen_enable && tready) obs_issues++;
      if (gen_tvalid) begin
        obs_data.push_back(gen_data);
        obs_beats++;
      end
      if (frame_tlast) begin
        obs_tlast_cnt++;
        obs_tlast_idx = obs_beats;
      end
      if (done != 2'b00) begin
        obs_done_cnt++;
        obs_done_val = done;
        got = 1;
      end
    end
    if (!got) obs_timeout = 1;
    @(negedge clk);
    obs_gap_grant = grant;
    obs_gap_done = done;
    req = 2'b00;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    req = 2'b00; req_len0 = '0; req_len1 = '0; tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant got %b want 00", grant); end
    n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL rst_done got %b want 00", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (gen_enable !== 1'b0) begin n_bad++; $display("FAIL rst_en got %b want 0", gen_enable); end
    n_cmp++; if (gen_aresetn !== 1'b0) begin n_bad++; $display("FAIL rst_aresetn got %b want 0", gen_aresetn); end
    n_cmp++; if (frame_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast got %b want 0", frame_tlast); end
    areset = 1'b0;
    exp_last = 1;
    @(negedge clk);
    n_cmp++; if (gen_aresetn !== 1'b1) begin n_bad++; $display("FAIL idle_aresetn got %b want 1", gen_aresetn); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    run_frame(2'b01, W'(3), W'(0), 0, 0, 0);
    n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL basic_timeout got 1 want 0"); end
    n_cmp++; if (obs_grant !== 2'b01) begin n_bad++; $display("FAIL basic_grant got %b want 01", obs_grant); end
    n_cmp++; if (obs_rst_cycles != 1) begin n_bad++; $display("FAIL basic_restart got %0d want 1", obs_rst_cycles); end
    n_cmp++; if (obs_en_cycles != 3) begin n_bad++; $display("FAIL basic_enable got %0d want 3", obs_en_cycles); end
    n_cmp++; if (obs_beats != 3) begin n_bad++; $display("FAIL basic_beats got %0d want 3", obs_beats); end
    for (int i = 0; i < obs_data.size() && i < 3; i++) begin
      n_cmp++;
      if (obs_data[i] !== pow3(i + 1)) begin
        n_bad++; $display("FAIL basic_data[%0d] got %0d want %0d", i, obs_data[i], pow3(i + 1));
      end
    end
    n_cmp++; if (obs_tlast_cnt != 1 || obs_tlast_idx != 3) begin
      n_bad++; $display("FAIL basic_tlast got cnt %0d idx %0d want 1/3", obs_tlast_cnt, obs_tlast_idx);
    end
    n_cmp++; if (obs_done_cnt != 1 || obs_done_val !== 2'b01 || obs_gap_done !== 2'b00) begin
      n_bad++; $display("FAIL basic_done got %0d/%b/%b want 1/01/00", obs_done_cnt, obs_done_val,
                        obs_gap_done);
    end
    exp_last = 0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      want = (f % 2 == 0) ? 2'b01 : 2'b10;
      run_frame(2'b11, W'(2), W'(2), 0, 1, 0);
      req = 2'b11;
      n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL b2b_timeout[%0d] got 1 want 0", f); end
      n_cmp++; if (obs_grant !== want) begin n_bad++; $display("FAIL b2b_grant[%0d] got %b want %b", f, obs_grant, want); end
      n_cmp++; if (obs_gap_grant !== 2'b00) begin n_bad++; $display("FAIL b2b_gap[%0d] got %b want 00", f, obs_gap_grant); end
      n_cmp++; if (obs_beats != 2) begin n_bad++; $display("FAIL b2b_beats[%0d] got %0d want 2", f, obs_beats); end
      exp_last = (want == 2'b10) ? 1 : 0;
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_toggle();
    run_frame(2'b10, W'(0), W'(4), 1, 0, 0);
    n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL tog_timeout got 1 want 0"); end
    n_cmp++; if (obs_grant !== 2'b10) begin n_bad++; $display("FAIL tog_grant got %b want 10", obs_grant); end
    n_cmp++; if (obs_issues != 4) begin n_bad++; $display("FAIL tog_issues got %0d want 4", obs_issues); end
    n_cmp++; if (obs_beats != 4) begin n_bad++; $display("FAIL tog_beats got %0d want 4", obs_beats); end
    n_cmp++; if (obs_tlast_cnt != 1 || obs_tlast_idx != 4) begin
      n_bad++; $display("FAIL tog_tlast got cnt %0d idx %0d want 1/4", obs_tlast_cnt, obs_tlast_idx);
    end
    n_cmp++; if (obs_done_cnt != 1 || obs_done_val !== 2'b10) begin
      n_bad++; $display("FAIL tog_done got %0d/%b want 1/10", obs_done_cnt, obs_done_val);
    end
    exp_last = 1;
  endtask

  task automatic test_zero_len();
    run_frame(2'b01, W'(0), W'(5), 0, 0, 0);
    n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL zero_timeout got 1 want 0"); end
    n_cmp++; if (obs_grant !== 2'b01) begin n_bad++; $display("FAIL zero_grant got %b want 01", obs_grant); end
    n_cmp++; if (obs_rst_cycles != 1) begin n_bad++; $display("FAIL zero_restart got %0d want 1", obs_rst_cycles); end
    n_cmp++; if (obs_en_cycles != 0 || obs_beats != 0) begin
      n_bad++; $display("FAIL zero_enable got en %0d beats %0d want 0/0", obs_en_cycles, obs_beats);
    end
    n_cmp++; if (obs_tlast_cnt != 0) begin n_bad++; $display("FAIL zero_tlast got %0d want 0", obs_tlast_cnt); end
    n_cmp++; if (obs_done_cnt != 1 || obs_done_val !== 2'b01 || obs_cycles != 1) begin
      n_bad++; $display("FAIL zero_done got %0d/%b after %0d want 1/01 after 1", obs_done_cnt,
                        obs_done_val, obs_cycles);
    end
    exp_last = 0;
  endtask

  task automatic test_abort();
    bit got = 0;
    int beats = 0;
    int dones = 0;
    req = 2'b01; req_len0 = W'(5); tready = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (gen_tvalid) beats++;
      if (beats == 2) got = 1;
    end
    req = 2'b00;
    n_cmp++; if (!got) begin n_bad++; $display("FAIL abort_reach got %0d beats want 2", beats); end
    areset = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_state got grant %b done %b busy %b want 00/00/0", grant, done, busy);
    end
    n_cmp++; if (gen_enable !== 1'b0 || gen_aresetn !== 1'b0 || frame_tlast !== 1'b0) begin
      n_bad++; $display("FAIL abort_gen got en %b rstn %b tlast %b want 0/0/0", gen_enable,
                        gen_aresetn, frame_tlast);
    end
    areset = 1'b0;
    exp_last = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done != 2'b00) dones++;
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_nodone got %0d want 0", dones); end
    run_frame(2'b01, W'(3), W'(0), 0, 0, 0);
    n_cmp++; if (obs_timeout || obs_grant !== 2'b01) begin
      n_bad++; $display("FAIL abort_regrant got %b want 01", obs_grant);
    end
    n_cmp++; if (obs_beats != 3 || obs_data.size() == 0 || obs_data[0] !== 32'd3) begin
      n_bad++; $display("FAIL abort_restart got %0d beats want 3 starting at 3", obs_beats);
    end
    exp_last = 0;
  endtask

  task automatic test_len_change();
    run_frame(2'b01, W'(5), W'(1), 0, 0, 1);
    n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL chg_timeout got 1 want 0"); end
    n_cmp++; if (obs_issues != 5 || obs_beats != 5) begin
      n_bad++; $display("FAIL chg_beats got issues %0d beats %0d want 5/5", obs_issues, obs_beats);
    end
    n_cmp++; if (obs_tlast_idx != 5) begin n_bad++; $display("FAIL chg_tlast got %0d want 5", obs_tlast_idx); end
    exp_last = 0;
  endtask

  task automatic test_stall();
    run_frame(2'b10, W'(0), W'(3), 3, 0, 0);
    n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL stall_timeout got 1 want 0"); end
    n_cmp++; if (obs_cycles < 40) begin n_bad++; $display("FAIL stall_len got %0d cycles want >=40", obs_cycles); end
    n_cmp++; if (obs_beats != 3 || obs_tlast_idx != 3 || obs_done_cnt != 1) begin
      n_bad++; $display("FAIL stall_frame got beats %0d tlast %0d done %0d want 3/3/1", obs_beats,
                        obs_tlast_idx, obs_done_cnt);
    end
    exp_last = 1;
  endtask

  task automatic test_max_len();
    run_frame(2'b01, W'(15), W'(0), 0, 0, 0);
    n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL max_timeout got 1 want 0"); end
    n_cmp++; if (obs_beats != 15 || obs_tlast_idx != 15 || obs_tlast_cnt != 1) begin
      n_bad++; $display("FAIL max_frame got beats %0d tlast %0d/%0d want 15/15/1", obs_beats,
                        obs_tlast_idx, obs_tlast_cnt);
    end
    n_cmp++; if (obs_data.size() != 15 || obs_data[14] !== pow3(15)) begin
      n_bad++; $display("FAIL max_data got %0d entries want 15 ending %0d", obs_data.size(), pow3(15));
    end
    exp_last = 0;
  endtask

  task automatic test_random();
    logic [1:0]   r, want;
    logic [W-1:0] l0, l1;
    int p, len;
    for (int f = 0; f < 12; f++) begin
      r  = 2'($urandom_range(1, 3));
      l0 = W'($urandom_range(0, 15));
      l1 = W'($urandom_range(0, 15));
      p = pick(r);
      len = p ? int'(l1) : int'(l0);
      want = (p == 1) ? 2'b10 : 2'b01;
      run_frame(r, l0, l1, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
      n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL rnd_timeout[%0d] got 1 want 0", f); end
      n_cmp++; if (obs_grant !== want) begin n_bad++; $display("FAIL rnd_grant[%0d] got %b want %b", f, obs_grant, want); end
      n_cmp++; if (obs_issues != len || obs_beats != len) begin
        n_bad++; $display("FAIL rnd_beats[%0d] got issues %0d beats %0d want %0d", f, obs_issues, obs_beats, len);
      end
      for (int i = 0; i < obs_data.size() && i < len; i++) begin
        n_cmp++;
        if (obs_data[i] !== pow3(i + 1)) begin
          n_bad++; $display("FAIL rnd_data[%0d][%0d] got %0d want %0d", f, i, obs_data[i], pow3(i + 1));
        end
      end
      n_cmp++; if (obs_tlast_cnt != ((len != 0) ? 1 : 0) || obs_tlast_idx != len) begin
        n_bad++; $display("FAIL rnd_tlast[%0d] got cnt %0d idx %0d want idx %0d", f, obs_tlast_cnt, obs_tlast_idx, len);
      end
      n_cmp++; if (obs_done_cnt != 1 || obs_done_val !== want || obs_gap_done !== 2'b00) begin
        n_bad++; $display("FAIL rnd_done[%0d] got %0d/%b want 1/%b", f, obs_done_cnt, obs_done_val, want);
      end
      n_cmp++; if (obs_gap_grant !== 2'b00) begin n_bad++; $display("FAIL rnd_gap[%0d] got %b want 00", f, obs_gap_grant); end
      exp_last = p;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_toggle();
    test_zero_len();
    test_abort();
    test_len_change();
    test_stall();
    test_max_len();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
